// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data-memory responder for the CPU data bus. Holds a word-organised RAM and
// serves big-endian byte / halfword / word loads and stores, inserting
// WAIT_CYCLES wait states before a one-cycle active-low completion strobe.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   DAD     in   [31:0] byte address; only DAD[DEPTH_LOG2+1:0] is used
//   MREQ    in   request valid, sampled only while idle
//   WRITE   in   1 = store, 0 = load; sampled with MREQ
//   SIZE    in   [1:0] 00 word, 01 halfword, 10 byte, 11 reserved (error)
//   DDT     io   [31:0] store data in, right-justified load data out
//   ACKD_n  out  active-low completion strobe, one cycle per access
//   err     out  high with ACKD_n for misaligned or reserved-size accesses
//
// state  | meaning
// S_IDLE | waiting for MREQ; latches the request on acceptance
// S_WAIT | counting wait states, inputs ignored
// S_ACK  | ACKD_n low for one cycle, load data driven on DDT

module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DAD,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n,
  output logic        err
);

  localparam int         AW        = DEPTH_LOG2 + 2;
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        live_q;

  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;

  logic [AW-1:0]         acc_addr;
  logic                  acc_write;
  logic [1:0]            acc_size;
  logic [31:0]           acc_wdata;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_mis;

  logic        accept;
  logic        enter_ack;
  logic        mem_we;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] rd_word;
  logic [31:0] rd_lanes;

  logic        ack_n_q;
  logic        err_q;
  logic        oe_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [0:DEPTH-1];

  logic unused_dad;
  assign unused_dad = ^DAD[31:AW];

  // live_q holds off acceptance while reset is asserted and for the first
  // edge after release, so no RAM write can slip through during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live_q <= 1'b0;
    else      live_q <= 1'b1;
  end

  assign accept = MREQ && live_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_ack = (state_d == S_ACK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= 32'd0;
    end else if (state_q == S_IDLE && accept) begin
      addr_q  <= DAD[AW-1:0];
      write_q <= WRITE;
      size_q  <= SIZE;
      if (WRITE) wdata_q <= DDT;
    end
  end

  // With no wait states the ACK-entry edge is the acceptance edge itself, so
  // the access is taken straight from the bus while idle and from the
  // latched copy otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = DAD[AW-1:0];
      acc_write = WRITE;
      acc_size  = SIZE;
      acc_wdata = DDT;
    end else begin
      acc_addr  = addr_q;
      acc_write = write_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx = acc_addr[AW-1:2];

  always_comb begin
    acc_mis = 1'b0;
    case (acc_size)
      2'b00:   acc_mis = |acc_addr[1:0];
      2'b01:   acc_mis = acc_addr[0];
      2'b10:   acc_mis = 1'b0;
      default: acc_mis = 1'b1;
    endcase
  end

  // Big-endian lanes: byte_en[3] is bits [31:24], i.e. DAD[1:0] = 0.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = acc_wdata;
    case (acc_size)
      2'b00: begin
        byte_en  = 4'b1111;
        wr_lanes = acc_wdata;
      end
      2'b01: begin
        byte_en  = acc_addr[1] ? 4'b0011 : 4'b1100;
        wr_lanes = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        byte_en  = 4'b1000 >> acc_addr[1:0];
        wr_lanes = {4{acc_wdata[7:0]}};
      end
      default: begin
        byte_en  = 4'b0000;
        wr_lanes = acc_wdata;
      end
    endcase
  end

  assign rd_word = mem[acc_idx];

  always_comb begin
    rd_lanes = 32'd0;
    case (acc_size)
      2'b00: rd_lanes = rd_word;
      2'b01: rd_lanes = acc_addr[1] ? {16'd0, rd_word[15:0]}
                                    : {16'd0, rd_word[31:16]};
      2'b10: begin
        case (acc_addr[1:0])
          2'b00:   rd_lanes = {24'd0, rd_word[31:24]};
          2'b01:   rd_lanes = {24'd0, rd_word[23:16]};
          2'b10:   rd_lanes = {24'd0, rd_word[15:8]};
          default: rd_lanes = {24'd0, rd_word[7:0]};
        endcase
      end
      default: rd_lanes = 32'd0;
    endcase
  end

  assign mem_we = enter_ack && acc_write && !acc_mis;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[acc_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_n_q <= 1'b1;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_n_q <= !enter_ack;
      err_q   <= enter_ack && acc_mis;
      oe_q    <= enter_ack && !acc_write;
      if (enter_ack && !acc_write) rdata_q <= acc_mis ? 32'd0 : rd_lanes;
    end
  end

  assign ACKD_n = ack_n_q;
  assign err    = err_q;
  assign DDT    = oe_q ? rdata_q : 32'hzzzz_zzzz;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data bus (DAD/MREQ/WRITE/SIZE/DDT/ACKD_n).
- Holds a word-organised RAM and serves byte, halfword and word loads and stores.
- Adds a programmable number of wait states and signals completion with a one-cycle active-low ACKD_n pulse.
- Sits outside the core as the data-memory model/controller used in system simulation and on the FPGA build.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words; index = DAD[DEPTH_LOG2+1:2], upper address bits ignored (aliasing).
- WAIT_CYCLES, 1, wait states inserted between request acceptance and ACK (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- DAD  input  32  byte address from the CPU.
- MREQ  input  1  request valid, sampled only in IDLE.
- WRITE  input  1  1 = store, 0 = load; sampled with MREQ.
- SIZE  input  2  00 = word, 01 = halfword, 10 = byte, 11 = reserved (treated as misaligned).
- DDT  inout  32  store data in, load data out; right-justified for byte/halfword.
- ACKD_n  output  1  active-low completion strobe, one cycle per access.
- err  output  1  high with ACKD_n when the access was misaligned or SIZE=11.

Behaviour:
- FSM states: IDLE, WAIT, ACK. Registered outputs. Reset puts FSM in IDLE, ACKD_n=1, err=0, DDT=Z. RAM contents are not reset.
- IDLE, on a clock edge with MREQ=1:
  - latch DAD, WRITE, SIZE and (if WRITE) DDT;
  - go to ACK if WAIT_CYCLES=0, else to WAIT with cnt=WAIT_CYCLES.
- WAIT: decrement cnt each cycle; when cnt=1, next state is ACK. MREQ and other inputs are ignored.
- The edge that enters ACK:
  - store: commits the byte-masked write;
  - load: registers the aligned, zero-extended read data.
- ACK (exactly one cycle): ACKD_n=0; err is valid; DDT is driven with read data only if the latched WRITE=0, otherwise Z. Next state is IDLE.
- Latency: request sampled at edge t → ACKD_n low for the cycle after edge t+WAIT_CYCLES.
- Back-to-back: a new MREQ is accepted in the first IDLE cycle after ACK. The requester must deassert MREQ in that cycle if it has no new access; a held MREQ is taken as a new access.
- Byte ordering is big-endian:
  - byte lane k = DAD[1:0] maps to bits [31-8k:24-8k];
  - halfword: DAD[1]=0 → [31:16], DAD[1]=1 → [15:0];
  - store source is DDT[7:0] for byte, DDT[15:0] for halfword, DDT[31:0] for word;
  - load returns the selected lane(s) zero-extended into DDT[31:0]; sign extension is done by the core.
- Misalignment (halfword with DAD[0]=1, word with DAD[1:0]≠0, SIZE=11):
  - no RAM write; load data = 0;
  - err=1 during ACK; normal ACK timing.
- DDT is never driven outside ACK, so there is no contention when the CPU drives store data.
- Reset mid-access: returns immediately to IDLE with no ACK. A store is lost if reset asserts before the ACK-entry edge.
- The RAM index wraps modulo 2^DEPTH_LOG2 words.

Test Plan:
- Word store then load (WAIT_CYCLES=1): store 0xDEADBEEF @0x0000_0010, then load @0x10 → each ACKD_n low exactly 1 cycle, 2 cycles after MREQ sample; load DDT=0xDEADBEEF, err=0.
- Byte store @0x13 of 0x0000_00AA over word 0x11223344 → word load returns 0x112233AA. Byte load @0x11 → 0x00000022.
- Halfword store 0x5566 @0x12 over word 0x11223344 → word load returns 0x11225566. Halfword load @0x10 → 0x00001122.
- Misaligned word load @0x0000_0012 → err=1 with ACKD_n, DDT=0; a misaligned halfword store @0x11 leaves memory unchanged.
- WAIT_CYCLES=0 back-to-back loads with MREQ held 4 cycles → ACKD_n low every other cycle (2 ACKs); DDT=Z in all non-ACK cycles.
- Assert rst during WAIT of a store @0x20 → ACKD_n stays 1, DDT=Z; after release, load @0x20 returns the prior contents.
